// File: rtl/rate_conv_scheduler_pkg.sv
// Shared types and constants for the stick-value to rate conversion path.
// Holds the channel index, the scheduler state enum, the clamp limits and the default gains.
package drone_rate_pkg;

  localparam int N_VAL   = 16;
  localparam int N_RATE  = 36;
  localparam int N_COEF  = 18;
  localparam int N_PROD  = N_VAL + N_COEF;

  localparam int MUL_LAT_DEF = 2;
  localparam int K_THR_DEF   = 1;
  localparam int K_YAW_DEF   = 200;
  localparam int K_ROLL_DEF  = 150;
  localparam int K_PITCH_DEF = 150;

  localparam int VAL_MAX = 9000;
  localparam int VAL_MIN = -9000;

  typedef logic [1:0] chan_t;
  localparam chan_t CH_THR   = 2'd0;
  localparam chan_t CH_YAW   = 2'd1;
  localparam chan_t CH_ROLL  = 2'd2;
  localparam chan_t CH_PITCH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_PUBLISH
  } state_t;

  function automatic logic signed [N_VAL-1:0] clamp_val(input logic signed [N_VAL-1:0] v);
    if (v > VAL_MAX)      return N_VAL'(VAL_MAX);
    else if (v < VAL_MIN) return N_VAL'(VAL_MIN);
    else                  return v;
  endfunction

endpackage

// File: rtl/rate_conv_scheduler_if.sv
// Stick-value in / rate out bundle between receiver decode and the PID stage.
// The producer of stick values owns the master side; the scheduler is the slave.
interface rate_conv_scheduler_if;
  import drone_rate_pkg::*;

  logic                     start;
  logic signed [N_VAL-1:0]  throttle_val;
  logic signed [N_VAL-1:0]  yaw_val;
  logic signed [N_VAL-1:0]  roll_val;
  logic signed [N_VAL-1:0]  pitch_val;
  logic signed [N_RATE-1:0] throttle_rate;
  logic signed [N_RATE-1:0] yaw_rate;
  logic signed [N_RATE-1:0] roll_rate;
  logic signed [N_RATE-1:0] pitch_rate;
  logic                     rates_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output start, throttle_val, yaw_val, roll_val, pitch_val,
    input  throttle_rate, yaw_rate, roll_rate, pitch_rate, rates_valid, busy, overrun
  );

  modport slave (
    input  start, throttle_val, yaw_val, roll_val, pitch_val,
    output throttle_rate, yaw_rate, roll_rate, pitch_rate, rates_valid, busy, overrun
  );

endinterface

// File: rtl/rate_conv_scheduler_mult.sv
// MUL_LAT-stage signed multiplier shared by all four channels.
// The channel tag rides alongside the product so results can be steered on the way out.
module rate_mult
  import drone_rate_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  chan_t                    in_tag,
  input  logic signed [N_VAL-1:0]  in_a,
  input  logic signed [N_COEF-1:0] in_b,
  output logic                     out_valid,
  output chan_t                    out_tag,
  output logic signed [N_PROD-1:0] out_p
);

  logic [MUL_LAT-1:0]       vld_pipe;
  chan_t                    tag_pipe  [MUL_LAT];
  logic signed [N_PROD-1:0] prod_pipe [MUL_LAT];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      for (int i = 1; i < MUL_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // NOTE: the data/tag pipeline has no reset; only the valid bits decide whether a stage means anything.
  always_ff @(posedge sys_clk) begin
    prod_pipe[0] <= N_PROD'(in_a) * N_PROD'(in_b);
    tag_pipe[0]  <= in_tag;
    for (int i = 1; i < MUL_LAT; i++) begin
      prod_pipe[i] <= prod_pipe[i-1];
      tag_pipe[i]  <= tag_pipe[i-1];
    end
  end

  assign out_valid = vld_pipe[MUL_LAT-1];
  assign out_tag   = tag_pipe[MUL_LAT-1];
  assign out_p     = prod_pipe[MUL_LAT-1];

endmodule

// File: rtl/rate_conv_scheduler.sv
// Latches and clamps four stick values, pushes them through one shared multiplier
// and publishes the four rates together with a single rates_valid pulse.
module rate_conv_scheduler
  import drone_rate_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int K_THR   = K_THR_DEF,
  parameter int K_YAW   = K_YAW_DEF,
  parameter int K_ROLL  = K_ROLL_DEF,
  parameter int K_PITCH = K_PITCH_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  rate_conv_scheduler_if.slave bus
);

  state_t                   state;
  chan_t                    issue_cnt;
  logic [2:0]               collect_cnt;
  logic signed [N_VAL-1:0]  hold   [4];
  logic signed [N_RATE-1:0] result [4];
  logic signed [N_RATE-1:0] rate_q [4];
  logic                     rates_valid_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic                     mul_in_valid;
  logic signed [N_VAL-1:0]  mul_in_a;
  logic signed [N_COEF-1:0] mul_in_b;
  logic                     mul_out_valid;
  chan_t                    mul_out_tag;
  logic signed [N_PROD-1:0] mul_out_p;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_in_valid = (state == ST_ISSUE);
    mul_in_a     = hold[issue_cnt];
    mul_in_b     = '0;
    case (issue_cnt)
      CH_THR:   mul_in_b = N_COEF'(K_THR);
      CH_YAW:   mul_in_b = N_COEF'(K_YAW);
      CH_ROLL:  mul_in_b = N_COEF'(K_ROLL);
      CH_PITCH: mul_in_b = N_COEF'(K_PITCH);
      default:  mul_in_b = '0;
    endcase
  end

  rate_mult #(
    .MUL_LAT (MUL_LAT)
  ) u_rate_mult (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .in_valid  (mul_in_valid),
    .in_tag    (issue_cnt),
    .in_a      (mul_in_a),
    .in_b      (mul_in_b),
    .out_valid (mul_out_valid),
    .out_tag   (mul_out_tag),
    .out_p     (mul_out_p)
  );

  // NOTE: state is updated with non-blocking assignments so every read in this block sees the pre-edge value.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      issue_cnt     <= '0;
      collect_cnt   <= '0;
      rates_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hold[i]   <= '0;
        result[i] <= '0;
        rate_q[i] <= '0;
      end
    end else begin
      rates_valid_q <= 1'b0;
      overrun_q     <= bus.start && (state != ST_IDLE);

      if (mul_out_valid) begin
        result[mul_out_tag] <= N_RATE'(mul_out_p);
        collect_cnt         <= collect_cnt + 3'd1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            hold[CH_THR]   <= clamp_val(bus.throttle_val);
            hold[CH_YAW]   <= clamp_val(bus.yaw_val);
            hold[CH_ROLL]  <= clamp_val(bus.roll_val);
            hold[CH_PITCH] <= clamp_val(bus.pitch_val);
            issue_cnt      <= '0;
            collect_cnt    <= '0;
            busy_q         <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          issue_cnt <= issue_cnt + 2'd1;
          if (issue_cnt == CH_PITCH) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // The last product may land in this very cycle; count it as already captured.
          if ((collect_cnt + {2'b00, mul_out_valid}) == 3'd4) state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          for (int i = 0; i < 4; i++) rate_q[i] <= result[i];
          rates_valid_q <= 1'b1;
          busy_q        <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.throttle_rate = rate_q[CH_THR];
  assign bus.yaw_rate      = rate_q[CH_YAW];
  assign bus.roll_rate     = rate_q[CH_ROLL];
  assign bus.pitch_rate    = rate_q[CH_PITCH];
  assign bus.rates_valid   = rates_valid_q;
  assign bus.busy          = busy_q;
  assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_rate_conv_scheduler.sv
// Scoreboard bench for rate_conv_scheduler: three instances (MUL_LAT 1/2/3) share one stimulus
// stream; a monitor per instance pops expected rate sets and checks values and publish cycle.
module tb_rate_conv_scheduler;
  import drone_rate_pkg::*;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  rate_conv_scheduler_if bus1 ();
  rate_conv_scheduler_if bus2 ();
  rate_conv_scheduler_if bus3 ();

  assign bus1.start        = bus2.start;
  assign bus1.throttle_val = bus2.throttle_val;
  assign bus1.yaw_val      = bus2.yaw_val;
  assign bus1.roll_val     = bus2.roll_val;
  assign bus1.pitch_val    = bus2.pitch_val;
  assign bus3.start        = bus2.start;
  assign bus3.throttle_val = bus2.throttle_val;
  assign bus3.yaw_val      = bus2.yaw_val;
  assign bus3.roll_val     = bus2.roll_val;
  assign bus3.pitch_val    = bus2.pitch_val;

  rate_conv_scheduler #(.MUL_LAT(1)) dut1 (.sys_clk(sys_clk), .rst(rst), .bus(bus1));
  rate_conv_scheduler #(.MUL_LAT(2)) dut2 (.sys_clk(sys_clk), .rst(rst), .bus(bus2));
  rate_conv_scheduler #(.MUL_LAT(3)) dut3 (.sys_clk(sys_clk), .rst(rst), .bus(bus3));

  typedef struct {
    int                       t;
    logic signed [N_RATE-1:0] thr;
    logic signed [N_RATE-1:0] yaw;
    logic signed [N_RATE-1:0] roll;
    logic signed [N_RATE-1:0] pitch;
    bit                       aborted;
  } exp_t;

  exp_t sb[$];
  int   rd  [3] = '{0, 0, 0};
  int   got [3] = '{0, 0, 0};

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon(input int i, input int lat, input logic signed [N_RATE-1:0] a,
                     input logic signed [N_RATE-1:0] b, input logic signed [N_RATE-1:0] c,
                     input logic signed [N_RATE-1:0] d);
    exp_t e;
    while (rd[i] < sb.size() && sb[rd[i]].aborted) rd[i]++;
    if (rd[i] >= sb.size()) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rates_valid lat%0d: got pulse at cycle %0d expected none", lat, cyc);
    end else begin
      e = sb[rd[i]];
      rd[i]++;
      got[i]++;
      check($sformatf("latency lat%0d", lat), cyc, e.t + 6 + lat);
      check($sformatf("throttle_rate lat%0d T=%0d", lat, e.t), a, e.thr);
      check($sformatf("yaw_rate lat%0d T=%0d", lat, e.t), b, e.yaw);
      check($sformatf("roll_rate lat%0d T=%0d", lat, e.t), c, e.roll);
      check($sformatf("pitch_rate lat%0d T=%0d", lat, e.t), d, e.pitch);
    end
  endtask

  always @(negedge sys_clk) if (bus1.rates_valid === 1'b1)
    mon(0, 1, bus1.throttle_rate, bus1.yaw_rate, bus1.roll_rate, bus1.pitch_rate);
  always @(negedge sys_clk) if (bus2.rates_valid === 1'b1)
    mon(1, 2, bus2.throttle_rate, bus2.yaw_rate, bus2.roll_rate, bus2.pitch_rate);
  always @(negedge sys_clk) if (bus3.rates_valid === 1'b1)
    mon(2, 3, bus3.throttle_rate, bus3.yaw_rate, bus3.roll_rate, bus3.pitch_rate);

  task automatic wait_cycle(input int c);
    do @(negedge sys_clk); while (cyc < c);
  endtask

  // Drives start for one cycle from the current negedge; returns the cycle start was high in.
  task automatic do_start(input logic signed [15:0] t, input logic signed [15:0] y,
                          input logic signed [15:0] r, input logic signed [15:0] p, output int tc);
    bus2.start        = 1'b1;
    bus2.throttle_val = t;
    bus2.yaw_val      = y;
    bus2.roll_val     = r;
    bus2.pitch_val    = p;
    tc = cyc;
    @(negedge sys_clk);
    bus2.start        = 1'b0;
    bus2.throttle_val = 16'sd4321;
    bus2.yaw_val      = -16'sd1234;
    bus2.roll_val     = 16'sd30000;
    bus2.pitch_val    = -16'sd30000;
  endtask

  task automatic push_exp(input int t, input longint a, input longint b, input longint c,
                          input longint d, output int idx);
    exp_t e;
    e.t = t;
    e.thr = N_RATE'(a);
    e.yaw = N_RATE'(b);
    e.roll = N_RATE'(c);
    e.pitch = N_RATE'(d);
    e.aborted = 1'b0;
    sb.push_back(e);
    idx = sb.size() - 1;
  endtask

  function automatic longint model(input int v, input int k);
    int c;
    c = (v > 9000) ? 9000 : ((v < -9000) ? -9000 : v);
    return longint'(c) * longint'(k);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by cycle %0d expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2, idx, n_live;
    logic signed [15:0] v [4];
    logic [63:0] raw;

    bus2.start = 1'b0;
    bus2.throttle_val = '0;
    bus2.yaw_val = '0;
    bus2.roll_val = '0;
    bus2.pitch_val = '0;

    wait_cycle(2);
    check("reset throttle_rate", bus2.throttle_rate, 0);
    check("reset yaw_rate", bus2.yaw_rate, 0);
    check("reset roll_rate", bus2.roll_rate, 0);
    check("reset pitch_rate", bus2.pitch_rate, 0);
    check("reset rates_valid", bus2.rates_valid, 0);
    check("reset busy", bus2.busy, 0);
    check("reset overrun", bus2.overrun, 0);
    rst = 1'b0;
    wait_cycle(4);

    // Single-channel roll, busy window and hold after publish.
    do_start(16'sd0, 16'sd0, 16'sd9000, 16'sd0, t);
    push_exp(t, 0, 0, 1350000, 0, idx);
    for (int k = 1; k <= 8; k++) begin
      if (cyc != t + k) wait_cycle(t + k);
      check($sformatf("busy T+%0d", k), bus2.busy, (k <= 7) ? 1 : 0);
    end
    wait_cycle(t + 10);
    check("roll_rate hold", bus2.roll_rate, 1350000);

    // Negative values.
    do_start(16'sd0, -16'sd1, 16'sd0, -16'sd9000, t);
    push_exp(t, 0, -200, 0, -1350000, idx);
    wait_cycle(t + 10);
    raw = {28'd0, bus2.pitch_rate};
    check("pitch_rate raw bits", raw, 64'h0000_000F_FFEB_6690);
    raw = {28'd0, bus2.yaw_rate};
    check("yaw_rate raw bits", raw, 64'h0000_000F_FFFF_FF38);

    // Clamping, including the exact limits and the 16-bit extremes.
    do_start(-16'sd20000, 16'sd12000, 16'sd0, 16'sd0, t);
    push_exp(t, -9000, 1800000, 0, 0, idx);
    wait_cycle(t + 10);
    do_start(16'sd9000, -16'sd9001, -16'sd32768, 16'sd32767, t);
    push_exp(t, 9000, -1800000, -1350000, 1350000, idx);
    wait_cycle(t + 10);

    // Start while busy is dropped with an overrun pulse; a start right after publish is taken.
    do_start(16'sd100, 16'sd10, 16'sd20, 16'sd30, t);
    push_exp(t, 100, 2000, 3000, 4500, idx);
    wait_cycle(t + 3);
    check("overrun before drop", bus2.overrun, 0);
    bus2.start = 1'b1;
    bus2.throttle_val = 16'sd5;
    bus2.yaw_val = 16'sd5;
    bus2.roll_val = 16'sd5;
    bus2.pitch_val = 16'sd5;
    wait_cycle(t + 4);
    bus2.start = 1'b0;
    check("overrun pulse", bus2.overrun, 1);
    wait_cycle(t + 5);
    check("overrun one cycle", bus2.overrun, 0);
    wait_cycle(t + 9);
    do_start(-16'sd50, -16'sd60, 16'sd70, -16'sd80, t2);
    push_exp(t2, -50, -12000, 10500, -12000, idx);
    check("back-to-back no overrun", bus2.overrun, 0);
    check("back-to-back busy", bus2.busy, 1);
    wait_cycle(t2 + 10);

    // Reset mid-operation aborts the in-flight set.
    do_start(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, t);
    push_exp(t, 1000, 200000, 150000, 150000, idx);
    sb[idx].aborted = 1'b1;
    wait_cycle(t + 4);
    rst = 1'b1;
    #1;
    check("abort throttle_rate", bus2.throttle_rate, 0);
    check("abort yaw_rate", bus2.yaw_rate, 0);
    check("abort roll_rate", bus2.roll_rate, 0);
    check("abort pitch_rate", bus2.pitch_rate, 0);
    check("abort busy", bus2.busy, 0);
    wait_cycle(t + 5);
    rst = 1'b0;
    wait_cycle(t + 20);
    do_start(16'sd7, 16'sd7, 16'sd7, 16'sd7, t);
    push_exp(t, 7, 1400, 1050, 1050, idx);
    wait_cycle(t + 10);

    // Random sets, mostly in the nominal range with some out-of-range values.
    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 3) == 0) v[j] = 16'($urandom_range(0, 65535));
        else                           v[j] = 16'(int'($urandom_range(0, 18000)) - 9000);
      end
      do_start(v[0], v[1], v[2], v[3], t);
      push_exp(t, model(int'(v[0]), 1), model(int'(v[1]), 200),
               model(int'(v[2]), 150), model(int'(v[3]), 150), idx);
      wait_cycle(t + 10);
    end
    wait_cycle(cyc + 6);

    n_live = 0;
    foreach (sb[i]) if (!sb[i].aborted) n_live++;
    for (int i = 0; i < 3; i++) check($sformatf("sets published lat%0d", i + 1), got[i], n_live);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
